// File: rtl/npc_lsu_pkg.sv
// npc_lsu_pkg: shared types and constants for the load/store unit.
// FSM state encoding, access size codes, funct3 opcodes and small helpers.
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Byte-enable pattern of an access at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Natural alignment: offset must be a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] low_bits;
    case (size)
      SZ_B:    low_bits = 3'b000;
      SZ_H:    low_bits = 3'b001;
      SZ_W:    low_bits = 3'b011;
      default: low_bits = 3'b111;
    endcase
    is_misaligned = (off & low_bits) != 3'b000;
  endfunction

endpackage

// File: rtl/npc_lsu_if.sv
// npc_lsu_if: 64-bit valid/ready data memory bus between the LSU and memory.
// master = LSU side, slave = memory side.
interface npc_lsu_if #(
  parameter int ADDR_W = 64
);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_req_addr;
  logic              bus_req_wen;
  logic [63:0]       bus_req_wdata;
  logic [7:0]        bus_req_wstrb;
  logic              bus_resp_valid;
  logic [63:0]       bus_resp_rdata;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata
  );
endinterface

// File: rtl/npc_lsu_lane_align.sv
// npc_lsu_lane_align: combinational byte-lane steering for the LSU.
// Store side shifts data and strobes up to the byte offset; load side shifts
// the returned doubleword down, masks to the access size and extends.
// Lanes shifted past byte 7 simply fall off, which is what an unaligned
// access crossing the doubleword sees when no alignment trap is built in.
module npc_lsu_lane_align
  import npc_lsu_pkg::*;
(
  input  logic [2:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [63:0] st_wdata,
  output logic [63:0] st_data,
  output logic [7:0]  st_strb,
  input  logic [2:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_data
);

  logic [63:0] ld_shift;
  logic [63:0] ld_mask;
  logic        ld_sign;

  // Store: move the LSB-justified value and its byte enables up to the lane offset.
  always_comb begin
    st_data = st_wdata << {st_off, 3'b000};
    st_strb = size_mask(st_size) << st_off;
  end

  // Load: bring the addressed bytes down to lane 0, keep the access width, extend.
  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    ld_mask  = '1;
    ld_sign  = 1'b0;
    case (ld_size)
      SZ_B:    begin ld_mask = 64'h0000_0000_0000_00FF; ld_sign = ld_shift[7];  end
      SZ_H:    begin ld_mask = 64'h0000_0000_0000_FFFF; ld_sign = ld_shift[15]; end
      SZ_W:    begin ld_mask = 64'h0000_0000_FFFF_FFFF; ld_sign = ld_shift[31]; end
      default: begin ld_mask = '1;                      ld_sign = 1'b0;         end
    endcase
    ld_data = ld_shift & ld_mask;
    if (!ld_unsigned && ld_sign) begin
      ld_data = ld_data | ~ld_mask;
    end
  end

endmodule

// File: rtl/npc_lsu.sv
// npc_lsu: load/store unit. Takes one access from the datapath, runs it on
// the valid/ready memory bus and returns a one-cycle completion pulse.
// Build option: define LSU_MISALIGN_TRAP_EN to complete misaligned accesses
// immediately with mem_misalign=1 and no bus traffic.
//
// state   | meaning
// IDLE    | waiting for mem_en; captures the access
// REQ     | bus_req_valid high, waiting for bus_req_ready
// WAIT    | request accepted, waiting for bus_resp_valid
// DONE    | mem_finish pulse, result on mem_rdata / mem_misalign
module npc_lsu
  import npc_lsu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_wdata,
  output logic              mem_finish,
  output logic [63:0]       mem_rdata,
  output logic              mem_misalign,
  output logic              mem_busy,
  npc_lsu_if.master         bus
);

  lsu_state_e  state;
  logic [2:0]  cap_off;
  logic [1:0]  cap_size;
  logic        cap_uns;
  logic [63:0] st_data;
  logic [7:0]  st_strb;
  logic [63:0] ld_data;
  logic        req_trap;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_trap = is_misaligned(mem_addr[2:0], mem_funct3[1:0]);
`else
  assign req_trap = 1'b0;
`endif

  // Store alignment works on the live request so the bus fields are ready in REQ;
  // load alignment works on the captured offset/size when the response arrives.
  npc_lsu_lane_align u_align (
    .st_off      (mem_addr[2:0]),
    .st_size     (mem_funct3[1:0]),
    .st_wdata    (mem_wdata),
    .st_data     (st_data),
    .st_strb     (st_strb),
    .ld_off      (cap_off),
    .ld_size     (cap_size),
    .ld_unsigned (cap_uns),
    .ld_rdata    (bus.bus_resp_rdata),
    .ld_data     (ld_data)
  );

  // Access sequencer with registered outputs; bus fields hold steady from capture to accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      cap_off           <= '0;
      cap_size          <= '0;
      cap_uns           <= 1'b0;
      mem_finish        <= 1'b0;
      mem_misalign      <= 1'b0;
      mem_busy          <= 1'b0;
      mem_rdata         <= '0;
      bus.bus_req_valid <= 1'b0;
      bus.bus_req_addr  <= '0;
      bus.bus_req_wen   <= 1'b0;
      bus.bus_req_wdata <= '0;
      bus.bus_req_wstrb <= '0;
    end else begin
      mem_finish   <= 1'b0;
      mem_misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_en) begin
            cap_off  <= mem_addr[2:0];
            cap_size <= mem_funct3[1:0];
            cap_uns  <= mem_funct3[2];
            mem_busy <= 1'b1;
            if (req_trap) begin
              state        <= ST_DONE;
              mem_finish   <= 1'b1;
              mem_misalign <= 1'b1;
              mem_rdata    <= '0;
            end else begin
              state             <= ST_REQ;
              bus.bus_req_valid <= 1'b1;
              bus.bus_req_addr  <= {mem_addr[ADDR_W-1:3], 3'b000};
              bus.bus_req_wen   <= mem_wr;
              bus.bus_req_wdata <= st_data;
              bus.bus_req_wstrb <= mem_wr ? st_strb : 8'h00;
            end
          end
        end
        ST_REQ: begin
          if (bus.bus_req_ready) begin
            state             <= ST_WAIT;
            bus.bus_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.bus_resp_valid) begin
            state      <= ST_DONE;
            mem_finish <= 1'b1;
            mem_rdata  <= bus.bus_req_wen ? 64'd0 : ld_data;
          end
        end
        default: begin
          state    <= ST_IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: directed vector table, reset-in-flight sequence and randomized
// accesses checked against a byte-level reference model.
module tb_npc_lsu;
  import npc_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wr;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_finish, mem_misalign, mem_busy;
  logic [63:0] mem_rdata;

  npc_lsu_if #(.ADDR_W(64)) bus();

  npc_lsu #(.ADDR_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_funct3   (mem_funct3),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_finish   (mem_finish),
    .mem_rdata    (mem_rdata),
    .mem_misalign (mem_misalign),
    .mem_busy     (mem_busy),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic        mis;
    logic        trap;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          rd;
    int          rs;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: walk the access byte by byte from the spec rules.
  function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] rdata,
                                 input int rd, input int rs);
    exp_t e;
    int off, n;
    logic [63:0] val, mask;
    off = int'(addr[2:0]);
    n = 1 << f3[1:0];
    e.addr = addr & ~64'h7;
    e.wdata = '0;
    e.wstrb = '0;
    val = '0;
    for (int j = off; j < 8; j++) e.wdata[8*j +: 8] = wdata[8*(j-off) +: 8];
    for (int i = 0; i < n; i++) begin
      if (off + i < 8) begin
        if (wr) e.wstrb[off+i] = 1'b1;
        val[8*i +: 8] = rdata[8*(off+i) +: 8];
      end
    end
    if (!wr) e.wstrb = '0;
    if (n < 8 && !f3[2]) begin
      mask = (64'd1 << (8*n)) - 64'd1;
      if (val[8*n-1]) val = val | ~mask;
    end
    e.rdata = wr ? 64'd0 : val;
`ifdef LSU_MISALIGN_TRAP_EN
    e.mis = (off % n) != 0;
`else
    e.mis = 1'b0;
`endif
    e.trap = e.mis;
    e.cyc = e.trap ? 1 : 3 + rd + rs;
    if (e.trap) e.rdata = '0;
    return e;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] rdata, input int rd,
                              input int rs, input logic [63:0] e_wdata, input logic [7:0] e_wstrb,
                              input logic [63:0] e_rdata, input logic e_mis, input int e_cyc);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rd = rd; v.rs = rs;
    v.e.addr = addr & ~64'h7;
    v.e.wdata = e_wdata; v.e.wstrb = e_wstrb; v.e.rdata = e_rdata;
    v.e.mis = e_mis; v.e.trap = e_mis; v.e.cyc = e_cyc;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; acts as the memory and checks the result.
  task automatic run_access(input string nm, input logic wr, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [63:0] rdata, input int rd, input int rs, input exp_t e);
    int fin_c, req_cnt, wait_cnt;
    bit accepted, responded, saw_valid;
    fin_c = -1; req_cnt = 0; wait_cnt = 0;
    accepted = 0; responded = 0; saw_valid = 0;
    mem_en = 1'b1; mem_wr = wr; mem_funct3 = f3; mem_addr = addr; mem_wdata = wdata;
    for (int c = 1; c <= 60 && fin_c < 0; c++) begin
      @(posedge clk); #1;
      mem_en = 1'b0;
      mem_wdata = 64'($urandom);
      bus.bus_req_ready = 1'b0;
      bus.bus_resp_valid = 1'b0;
      bus.bus_resp_rdata = {$urandom, $urandom};
      @(negedge clk);
      if (mem_finish) begin
        fin_c = c;
        chk({nm, " finish_cycle"}, 64'(c), 64'(e.cyc));
        chk({nm, " rdata"}, mem_rdata, e.rdata);
        chk({nm, " misalign"}, {63'd0, mem_misalign}, {63'd0, e.mis});
        chk({nm, " busy_done"}, {63'd0, mem_busy}, 64'd1);
      end else if (bus.bus_req_valid) begin
        saw_valid = 1;
        chk({nm, " req_addr"}, bus.bus_req_addr, e.addr);
        chk({nm, " req_wen"}, {63'd0, bus.bus_req_wen}, {63'd0, wr});
        chk({nm, " req_wstrb"}, {56'd0, bus.bus_req_wstrb}, {56'd0, e.wstrb});
        if (wr) chk({nm, " req_wdata"}, bus.bus_req_wdata, e.wdata);
        if (req_cnt >= rd) begin
          bus.bus_req_ready = 1'b1;
          accepted = 1;
        end
        req_cnt++;
      end else if (accepted && !responded) begin
        chk({nm, " busy_wait"}, {63'd0, mem_busy}, 64'd1);
        if (wait_cnt >= rs) begin
          bus.bus_resp_valid = 1'b1;
          bus.bus_resp_rdata = rdata;
          responded = 1;
        end
        wait_cnt++;
      end
    end
    if (fin_c < 0) chk({nm, " finish_timeout"}, 64'd0, 64'd1);
    chk({nm, " bus_req_seen"}, {63'd0, saw_valid}, {63'd0, !e.trap});
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b0;
    bus.bus_resp_valid = 1'b0;
    @(negedge clk);
    chk({nm, " finish_once"}, {62'd0, mem_finish, mem_busy}, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " finish"}, {63'd0, mem_finish}, 64'd0);
    chk({nm, " misalign"}, {63'd0, mem_misalign}, 64'd0);
    chk({nm, " busy"}, {63'd0, mem_busy}, 64'd0);
    chk({nm, " rdata"}, mem_rdata, 64'd0);
    chk({nm, " req_valid"}, {63'd0, bus.bus_req_valid}, 64'd0);
    chk({nm, " req_wen"}, {63'd0, bus.bus_req_wen}, 64'd0);
    chk({nm, " req_addr"}, bus.bus_req_addr, 64'd0);
    chk({nm, " req_wdata"}, bus.bus_req_wdata, 64'd0);
    chk({nm, " req_wstrb"}, {56'd0, bus.bus_req_wstrb}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    exp_t e;
    logic wr;
    logic [2:0] f3;
    logic [63:0] addr, wdata, rdata;
    int rd, rs;

    rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; mem_funct3 = '0; mem_addr = '0; mem_wdata = '0;
    bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0; bus.bus_resp_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    vecs.push_back(mk(1, F3_SB, 64'h8000_0003, 64'hAB, 64'h0, 0, 0,
                      64'h0000_0000_AB00_0000, 8'h08, 64'h0, 0, 3));
    vecs.push_back(mk(0, F3_LB, 64'h8000_0006, 64'h0, 64'h0080_0000_0000_0000, 0, 0,
                      64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 0, 3));
    vecs.push_back(mk(0, F3_LBU, 64'h8000_0006, 64'h0, 64'h0080_0000_0000_0000, 0, 0,
                      64'h0, 8'h00, 64'h0000_0000_0000_0080, 0, 3));
    vecs.push_back(mk(0, F3_LW, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0,
                      64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321, 0, 3));
    vecs.push_back(mk(0, F3_LWU, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0,
                      64'h0, 8'h00, 64'h0000_0000_8765_4321, 0, 3));
    vecs.push_back(mk(1, F3_SD, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 4, 2,
                      64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 0, 9));
    vecs.push_back(mk(0, F3_LH, 64'h8000_000E, 64'h0, 64'h8001_0000_0000_0000, 1, 1,
                      64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 0, 5));
    vecs.push_back(mk(0, F3_LHU, 64'h8000_000E, 64'h0, 64'h8001_0000_0000_0000, 0, 0,
                      64'h0, 8'h00, 64'h0000_0000_0000_8001, 0, 3));
    vecs.push_back(mk(0, F3_LD, 64'h8000_0008, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 3,
                      64'h0, 8'h00, 64'hFEDC_BA98_7654_3210, 0, 6));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, F3_LW, 64'h8000_0002, 64'h0, 64'h1122_3344_5566_7788, 0, 0,
                      64'h0, 8'h00, 64'h0, 1, 1));
    vecs.push_back(mk(1, F3_SW, 64'h8000_0002, 64'hDEAD_BEEF, 64'h0, 0, 0,
                      64'h0, 8'h00, 64'h0, 1, 1));
    vecs.push_back(mk(1, F3_SD, 64'h8000_0005, 64'h1122_3344_5566_7788, 64'h0, 0, 0,
                      64'h0, 8'h00, 64'h0, 1, 1));
    vecs.push_back(mk(0, F3_LD, 64'h8000_0005, 64'h0, 64'h1122_3344_5566_7788, 0, 0,
                      64'h0, 8'h00, 64'h0, 1, 1));
`else
    vecs.push_back(mk(0, F3_LW, 64'h8000_0002, 64'h0, 64'h1122_3344_5566_7788, 0, 0,
                      64'h0, 8'h00, 64'h0000_0000_3344_5566, 0, 3));
    vecs.push_back(mk(1, F3_SW, 64'h8000_0002, 64'hDEAD_BEEF, 64'h0, 0, 0,
                      64'h0000_DEAD_BEEF_0000, 8'h3C, 64'h0, 0, 3));
    vecs.push_back(mk(1, F3_SD, 64'h8000_0005, 64'h1122_3344_5566_7788, 64'h0, 0, 0,
                      64'h6677_8800_0000_0000, 8'hE0, 64'h0, 0, 3));
    vecs.push_back(mk(0, F3_LD, 64'h8000_0005, 64'h0, 64'h1122_3344_5566_7788, 0, 0,
                      64'h0, 8'h00, 64'h0000_0000_0011_2233, 0, 3));
`endif

    foreach (vecs[i]) begin
      v = vecs[i];
      run_access($sformatf("vec%0d", i), v.wr, v.f3, v.addr, v.wdata, v.rdata, v.rd, v.rs, v.e);
    end

    // Randomized accesses against the byte-level model.
    for (int n = 0; n < 150; n++) begin
      wr    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = {32'h0, 32'h8000_0000 + 32'($urandom_range(0, 4095))};
      wdata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      rd    = $urandom_range(0, 3);
      rs    = $urandom_range(0, 3);
      e = model(wr, f3, addr, wdata, rdata, rd, rs);
      run_access($sformatf("rnd%0d", n), wr, f3, addr, wdata, rdata, rd, rs, e);
    end

    // Reset while waiting for the response; the late response must be ignored.
    mem_en = 1'b1; mem_wr = 1'b0; mem_funct3 = F3_LB; mem_addr = 64'h8000_0006;
    @(posedge clk); #1;
    mem_en = 1'b0;
    bus.bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_wait busy_before", {63'd0, mem_busy}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.bus_resp_valid = 1'b1;
    bus.bus_resp_rdata = 64'h0080_0000_0000_0000;
    @(negedge clk);
    chk_reset_outputs("rst_in_wait");
    @(posedge clk); #1;
    bus.bus_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_reset_outputs($sformatf("after_rst%0d", k));
    end
    e = model(0, F3_LB, 64'h8000_0006, 64'h0, 64'h0080_0000_0000_0000, 0, 0);
    run_access("post_rst", 0, F3_LB, 64'h8000_0006, 64'h0, 64'h0080_0000_0000_0000, 0, 0, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npc_lsu.md
# npc_lsu

Load/store unit that executes the memory access requested by the decode stage and returns the completion pulse that gates register write-back. It accepts one access at a time from the datapath, issues it on a 64-bit valid/ready memory bus, aligns store data and byte strobes, and sign- or zero-extends load data per funct3. The unit sits between the control-unit/ALU datapath and the data memory port.

## Interface
- ADDR_W, 64, width of load/store address
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_en  in  1  access request, sampled only in IDLE
- mem_wr  in  1  1 = store, 0 = load
- mem_funct3  in  3  instr[14:12]; [1:0] size (0 B, 1 H, 2 W, 3 D), [2] unsigned (loads only)
- mem_addr  in  ADDR_W  effective byte address from ALU
- mem_wdata  in  64  rs2 value, LSB-justified
- mem_finish  out  1  one-cycle completion pulse (drives the core's ALU_MEM_Finish for memory ops)
- mem_rdata  out  64  extended load result, valid while mem_finish=1
- mem_misalign  out  1  misaligned-access flag, valid while mem_finish=1
- mem_busy  out  1  high in any state other than IDLE
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted when valid&ready
- bus_req_addr  out  ADDR_W  mem_addr with [2:0] forced to 0
- bus_req_wen  out  1  store request
- bus_req_wdata  out  64  lane-shifted store data
- bus_req_wstrb  out  8  byte enables, 0 for loads
- bus_resp_valid  in  1  read data / write ack, single cycle
- bus_resp_rdata  in  64  aligned doubleword

## Operation
- FSM: IDLE, REQ, WAIT, DONE.
- IDLE: if mem_en, capture wr, funct3, addr, wdata. Go to REQ, or to DONE when misaligned (macro enabled).
- REQ: bus_req_valid=1, request fields driven from capture registers and held stable. On bus_req_ready go to WAIT.
- WAIT: on bus_resp_valid, register the extended result and go to DONE.
- DONE: mem_finish=1 for exactly one cycle, then IDLE.
- off = addr[2:0]. Store: wdata = mem_wdata << 8*off; wstrb = ({1,3,15,255} by size) << off, truncated to 8 bits.
- Load: raw = bus_resp_rdata >> 8*off, masked to size. Sign-extend from the top bit of size when funct3[2]=0, else zero-extend. Size D ignores funct3[2].
- Stores ignore funct3[2].
- mem_rdata is 0 after a store or a misaligned access.
- Aligned: off mod (1<<size) == 0.
- mem_en in DONE, REQ or WAIT is ignored. mem_en still high in the IDLE cycle after DONE starts a new access, so the core must have advanced the instruction by then.
- bus_resp_valid outside WAIT is ignored.

## Timing
- Reset values: state IDLE; mem_finish, mem_misalign, mem_busy, bus_req_valid, bus_req_wen = 0; mem_rdata, bus_req_addr, bus_req_wdata, bus_req_wstrb = 0.
- Minimum latency, ready and resp asserted immediately: mem_en at cycle 0 → REQ at 1 → WAIT at 2 (resp at 2) → mem_finish at cycle 3.
- Each ready-low cycle in REQ and each resp-absent cycle in WAIT adds one cycle. There is no timeout.
- Misaligned with macro enabled: mem_finish and mem_misalign at cycle 1, and bus_req_valid is never asserted.
- rst in any state returns to IDLE next cycle and drops the outstanding transaction. A late response is then ignored in IDLE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: alignment check active. Misaligned accesses complete with mem_misalign=1, no bus traffic and no memory side effects.
- Macro undefined: no check and mem_misalign is tied 0. The access proceeds with off-based shifting. Bytes past lane 7 are dropped: strobe truncated, and the missing load bytes read as 0 before extension.

## Structure
- Package npc_lsu_pkg: FSM state enum; size codes SZ_B/SZ_H/SZ_W/SZ_D; funct3 constants for lb/lh/lw/ld/lbu/lhu/lwu/sb/sh/sw/sd.
- Sub-module npc_lsu_lane_align: purely combinational. Store shift/strobe generation and load shift/mask/extend, used by npc_lsu around its FSM.

## Test plan
- sb, addr 0x8000_0003, wdata 0xAB, ready/resp immediate → bus_req_addr 0x8000_0000, wstrb 0x08, wdata 0x0000_0000_AB00_0000, mem_finish at cycle 3.
- lb addr 0x8000_0006, resp rdata 0x0080_0000_0000_0000 → mem_rdata 0xFFFF_FFFF_FFFF_FF80. Same with lbu → 0x0000_0000_0000_0080.
- lw addr 0x8000_0004, rdata 0x8765_4321_0000_0000 → 0xFFFF_FFFF_8765_4321. lwu → 0x0000_0000_8765_4321.
- Backpressure: bus_req_ready low 4 cycles, resp 2 cycles after accept → request fields stable throughout, mem_finish exactly once at cycle 9.
- lw addr 0x8000_0002 with LSU_MISALIGN_TRAP_EN → mem_finish and mem_misalign at cycle 1, bus_req_valid never high. Without macro → wstrb/load uses lanes 2–5 normally.
- rst asserted in WAIT, bus_resp_valid one cycle later → all outputs return to reset values, no mem_finish, and the next access completes normally.
